// File: rtl/stopwatch_display_driver.sv
// Stopwatch MM:SS display driver: per-frame snapshot, BCD conversion and 4-digit seven-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module stopwatch_display_driver #(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       ovf
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_RSVD  = 2'b11
  } status_e;

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          started_q;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  status_e       st_q, st_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, ovf_q;

  logic          last_cnt, slot_adv, load;
  logic [7:0]    min_sat;
  logic          sec_bad;
  logic [3:0]    digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign last_cnt  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
  assign slot_adv  = started_q && last_cnt;
  assign load      = slot_adv && (idx_q == 2'd3);
  assign idx_d     = slot_adv ? idx_q + 2'd1 : idx_q;
  // The first edge after reset only presents slot 0, so that slot still lasts REFRESH_DIV cycles.
  assign ref_cnt_d = (!started_q || last_cnt) ? '0 : ref_cnt_q + 1'b1;

  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    st_d    = st_q;
    blink_d = blink_q;
    phase_d = phase_q;
    if (load) begin
      min_d = minutes;
      sec_d = seconds;
      st_d  = status_e'(status);
      if (st_d == ST_PAUSE && st_q == ST_PAUSE) begin
        if (blink_q == BW'(BLINK_FRAMES - 1)) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end else begin
        blink_d = '0;
        phase_d = 1'b0;
      end
    end
  end

  // Decode from next-state snapshot so the slot-0 value on a load edge already reflects it.
  always_comb begin
    min_sat = (min_d > 8'd99) ? 8'd99 : min_d;
    sec_bad = (sec_d > 6'd59);
    unique case (idx_d)
      2'd0: digit = 4'(sec_d % 6'd10);
      2'd1: digit = 4'(sec_d / 6'd10);
      2'd2: digit = 4'(min_sat % 8'd10);
      2'd3: digit = 4'(min_sat / 8'd10);
    endcase
    an_d  = 4'b0001 << idx_d;
    seg_d = seg7(digit);
    dp_d  = (idx_d == 2'd2);
    if (!idx_d[1] && sec_bad) seg_d = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx_d == 2'd3 && digit == 4'd0) seg_d = '0;
`endif
    if (st_d == ST_RSVD) begin
      seg_d = 7'h40;
      dp_d  = 1'b0;
    end else if (phase_d) begin
      seg_d = '0;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      started_q <= 1'b0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      st_q      <= ST_IDLE;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      an_q      <= '0;
      seg_q     <= '0;
      dp_q      <= 1'b0;
      fd_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      started_q <= 1'b1;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      st_q      <= st_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      fd_q      <= load;
      if (load) ovf_q <= (minutes > 8'd99);
      if (!started_q || slot_adv) begin
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Scoreboard bench for stopwatch_display_driver: frame-level reference model feeds expected slots to a monitor.
module tb_stopwatch_display_driver;

  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_done, ovf;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   rst_seen = 1'b1;
  logic [6:0] seg_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  stopwatch_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds), .status(status),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // One frame's worth of expected slots, built directly from the display rules.
  function automatic void push_frame(input int m, input int s, input int st, input bit dark, input bit fd);
    int   ms;
    int   d[4];
    exp_t e;
    ms   = (m > 99) ? 99 : m;
    d[0] = s % 10;
    d[1] = s / 10;
    d[2] = ms % 10;
    d[3] = ms / 10;
    for (int i = 0; i < 4; i++) begin
      e.an  = 4'(1 << i);
      e.seg = seg_tbl[d[i]];
      if (i < 2 && s > 59) e.seg = 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
      if (i == 3 && d[3] == 0) e.seg = 7'h00;
`endif
      e.dp = (i == 2);
      if (st == 3) begin
        e.seg = 7'h40;
        e.dp  = 1'b0;
      end else if (dark) begin
        e.seg = 7'h00;
        e.dp  = 1'b0;
      end
      e.fd  = fd && (i == 0);
      e.ovf = fd && (m > 99);
      exp_q.push_back(e);
    end
  endfunction

  // Reference model: frames start every FRAME cycles after reset release.
  initial begin
    int cyc, paused_run, snap_st;
    bit dark;
    cyc = 0; paused_run = 0; snap_st = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_q.delete();
        cyc = 0; paused_run = 0; snap_st = 0;
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        cyc++;
        if (cyc == 1) begin
          push_frame(0, 0, 0, 1'b0, 1'b0);
        end else if ((cyc - 1) % FRAME == 0) begin
          if (status == 2'b10) paused_run = (snap_st == 2) ? paused_run + 1 : 0;
          else paused_run = 0;
          snap_st = int'(status);
          dark = (status == 2'b10) && (((paused_run / BF) % 2) == 1);
          push_frame(int'(minutes), int'(seconds), int'(status), dark, 1'b1);
        end
      end
    end
  end

  // Monitor: each change of the digit enable is a presented slot.
  initial begin
    logic [3:0] prev_an;
    int  since;
    bit  have_prev;
    prev_an = '0; since = 0; have_prev = 1'b0;
    cur = '{an: 4'b0, seg: 7'b0, dp: 1'b0, fd: 1'b0, ovf: 1'b0};
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("rst_an", an, 0);
        chk("rst_seg", seg, 0);
        chk("rst_dp", dp, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovf", ovf, 0);
        prev_an = '0; since = 0; have_prev = 1'b0;
      end else if (an !== prev_an) begin
        if (have_prev) chk("slot_len", since, RD);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_slot: got an=%b expected no slot at %0t", an, $time);
        end else begin
          cur = exp_q.pop_front();
          chk("an", an, cur.an);
          chk("seg", seg, cur.seg);
          chk("dp", dp, cur.dp);
          chk("frame_done", frame_done, cur.fd);
          chk("ovf", ovf, cur.ovf);
        end
        prev_an = an; since = 1; have_prev = 1'b1;
      end else begin
        since++;
        if (have_prev) begin
          chk("hold_seg", seg, cur.seg);
          chk("hold_dp", dp, cur.dp);
          chk("hold_fd", frame_done, 0);
          chk("hold_ovf", ovf, cur.ovf);
        end
        if (since == RD + 1) begin
          checks++; errors++;
          $display("FAIL scan_stall: got %0d cycles without slot change expected %0d", since, RD);
        end
      end
    end
  end

  task automatic wait_slot(input logic [3:0] t);
    int n = 0;
    while (an !== t && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk("wait_slot", an, t);
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; minutes = '0; seconds = '0; status = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    minutes = 8'd12; seconds = 6'd34; status = 2'b01;
    frames(3);
    wait_slot(4'b0010);
    seconds = 6'd35;
    frames(2);
    minutes = 8'd5; seconds = 6'd7; status = 2'b10;
    frames(10);
    status = 2'b01;
    frames(3);
    minutes = 8'd150; frames(2);
    minutes = 8'd99;  frames(2);
    minutes = 8'd255; frames(2);
    minutes = 8'd42; seconds = 6'd60; frames(2);
    seconds = 6'd63; frames(2);
    seconds = 6'd18; status = 2'b11; frames(2);
    minutes = 8'd3; status = 2'b10;
    frames(4);
    wait_slot(4'b0100);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    frames(5);
    for (int i = 0; i < 150; i++) begin
      minutes = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 160));
      seconds = 6'($urandom);
      r = int'($urandom_range(0, 9));
      status = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      repeat ($urandom_range(1, 48)) @(negedge clk);
    end
    status = 2'b10;
    frames(9);
    frames(2);
    chk("leftover_slots", int'(exp_q.size() < 4), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_driver.md
Name: stopwatch_display_driver

Overview:
- Display-side consumer of the stopwatch time/status interface (minutes[7:0], seconds[5:0], status[1:0]).
- Snapshots the interface once per scan frame so a frame never tears, converts MM:SS to BCD, and time-multiplexes a 4-digit seven-segment display with a colon.
- Blinks the display while the stopwatch is paused.
- Sits between the stopwatch core and the board display pins.

Parameters:
- REFRESH_DIV, 4, clock cycles each digit slot is driven (frame = 4*REFRESH_DIV cycles); legal range is 2 or more.
- BLINK_FRAMES, 2, frames per blink half-period while paused; legal range is 1 or more.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- minutes  input  8  elapsed minutes from stopwatch
- seconds  input  6  elapsed seconds from stopwatch, legal 0..59
- status  input  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 reserved
- an  output  4  one-hot digit enable, active-high; bit0 = seconds ones, bit3 = minutes tens
- seg  output  7  segments {g,f,e,d,c,b,a}, active-high
- dp  output  1  colon, lit on the minutes-ones slot
- frame_done  output  1  one-cycle pulse when the snapshot loads
- ovf  output  1  snapshot minutes > 99

Behaviour:
- Reset is synchronous and active-low. One clock (clk). The reset is sampled on the clk edge.
- Values while rst_n=0:
  - an=0000, seg=0000000, dp=0, frame_done=0, ovf=0.
  - ref_cnt=0, digit_idx=0, blink counter=0, blink phase=0.
  - Snapshot registers = 0, snapshot status = IDLE.
- First edge with rst_n=1: an=0001, seg=7'h3F (shows 00:00).
- Scan:
  - ref_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx advances 0→1→2→3→0.
  - an, seg and dp are registered and change only on the edge where digit_idx changes (or the first edge after reset).
  - an always equals onehot(digit_idx).
- Snapshot:
  - Loads on the edge where digit_idx wraps 3→0.
  - Captures minutes, seconds and status.
  - The digit-0 value driven on that same edge already uses the new snapshot.
  - frame_done=1 for exactly that cycle.
  - Input changes mid-frame are invisible until the next frame.
  - Worst-case input-to-display latency is 4*REFRESH_DIV cycles.
- Conversion (combinational from the snapshot):
  - Minutes greater than 99 display 99 and set ovf=1. ovf is registered and updates with the snapshot.
  - Seconds greater than 59 (illegal) display "--" on both seconds digits (seg=7'h40).
- Digit encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.
- dp: 1 in slot 2, otherwise 0.
- Status handling (snapshot status):
  - IDLE/RUNNING: digits shown normally; blink counter and phase are held at 0.
  - PAUSED:
    - Blink counter counts frames.
    - Phase toggles every BLINK_FRAMES frames. The first paused frame is phase 0 (visible).
    - Phase 1: seg=0 and dp=0 on all slots; an keeps scanning.
  - 11 reserved: all four digits show a dash (seg=7'h40), dp=0, blink held at 0.
  - Leaving PAUSED: phase clears at the next snapshot, so that frame is visible.
- Reset mid-frame: the next edge forces the reset values above. No partial frame resumes.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: the minutes-tens digit is blank (seg=0) when its BCD value is 0, so 05:07 displays " 5:07". ovf saturation still shows 99.
- Undefined: the minutes-tens digit always shows its value, including a leading 0.

Test Plan:
- Reset with REFRESH_DIV=4: hold rst_n=0 for 3 cycles → an=0, seg=0, dp=0, frame_done=0. Release → first edge an=0001, seg=3F; the slot lasts 4 cycles.
- minutes=12, seconds=34, status=01 held → within 16 cycles each frame shows:
  - an=0001 seg=66
  - an=0010 seg=4F
  - an=0100 seg=5B dp=1
  - an=1000 seg=06
  - each slot is 4 cycles; frame_done pulses every 16 cycles.
- Change seconds 34→35 while in slot 1 → remainder of the frame still shows 3/4; the next frame shows 5 (6D) in slot 0.
- status=10 at 05:07 with BLINK_FRAMES=2 → 2 frames visible, then 2 frames with seg=0 and dp=0 (an still scanning), repeating. Setting status=01 → next frame visible and stays visible.
- Boundary values:
  - minutes=150 → displays 99, ovf=1.
  - minutes=99 → ovf=0.
  - seconds=60 → seconds digits 40.
  - status=11 → all slots seg=40.
- Pulse rst_n low for 1 cycle mid-frame (slot 2) → next edge all outputs 0 and the blink phase is cleared. After release the scan restarts at an=0001.
